// File: rtl/io_uart_leds_pkg.sv
// IO map shared by the LED/UART peripheral: word-address bit indices,
// status-word bit positions and the transmitter state encoding.
package io_uart_leds_pkg;

  // Byte address -> word index starts at bit 2
  localparam int ADDR_WORD_LSB    = 2;

  // One-hot word-address bits (relative to ADDR_WORD_LSB)
  localparam int IO_LEDS_BIT      = 0;
  localparam int IO_UART_DATA_BIT = 1;
  localparam int IO_UART_STAT_BIT = 2;

  // UART_STAT bit positions
  localparam int STAT_FULL_BIT    = 0;
  localparam int STAT_EMPTY_BIT   = 1;
  localparam int STAT_BUSY_BIT    = 2;
  localparam int STAT_OVF_BIT     = 3;
  localparam int STAT_CNT_LSB     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Assemble the software-visible status word
  function automatic logic [31:0] stat_word(input logic       full,
                                            input logic       empty,
                                            input logic       busy,
                                            input logic       ovf,
                                            input logic [7:0] cnt);
    logic [31:0] w;
    w                      = '0;
    w[STAT_FULL_BIT]       = full;
    w[STAT_EMPTY_BIT]      = empty;
    w[STAT_BUSY_BIT]       = busy;
    w[STAT_OVF_BIT]        = ovf;
    w[STAT_CNT_LSB +: 8]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/io_uart_leds_sync_fifo.sv
// sync_fifo: single-clock byte queue with fill count.
// Push is ignored when full, pop is ignored when empty; both flags are
// taken from the registered count, so a same-cycle pop never makes room.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, written on accepted push only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap modulo depth; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_leds.sv
// io_uart_leds: IO-space LED register, TX byte queue and 8N1 UART transmitter.
// Build option: define UART_TX_FIFO_EN for a 2**FIFO_DEPTH_LOG2-entry queue;
// otherwise a single holding register is used (depth 1).
module io_uart_leds
  import io_uart_leds_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 27_000_000,
  parameter int BAUD            = 115_200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [5:0]  leds,
  output logic        uart_tx
);

  localparam int DIV    = CLK_FREQ_HZ / BAUD;
  localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
`ifdef UART_TX_FIFO_EN
  localparam int FILL_W = FIFO_DEPTH_LOG2 + 1;
`else
  localparam int FILL_W = 1;
`endif

  logic              sel_leds;
  logic              sel_data;
  logic              sel_stat;
  logic              push_req;
  logic              ovf_clr;
  logic              overflow;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FILL_W-1:0] fifo_cnt;
  logic [7:0]        fifo_head;
  logic              fifo_pop;

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              bit_end;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              load;
  logic              shift;
  logic              tx_nxt;
  logic              tx_busy;

  logic              unused_ok;

  assign sel_leds = IO_mem_addr[ADDR_WORD_LSB + IO_LEDS_BIT];
  assign sel_data = IO_mem_addr[ADDR_WORD_LSB + IO_UART_DATA_BIT];
  assign sel_stat = IO_mem_addr[ADDR_WORD_LSB + IO_UART_STAT_BIT];
  assign push_req = IO_mem_wr & sel_data;
  assign ovf_clr  = IO_mem_wr & sel_stat & IO_mem_wdata[STAT_OVF_BIT];
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign tx_busy  = (state != ST_IDLE);

  // Address bits outside the one-hot decode and upper write-data bits are don't-care
  assign unused_ok = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:8],
                       (FIFO_DEPTH_LOG2 > 0)};

`ifdef UART_TX_FIFO_EN
  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (IO_mem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
`else
  logic       hold_vld;
  logic [7:0] hold_data;

  assign fifo_full  = hold_vld;
  assign fifo_empty = ~hold_vld;
  assign fifo_cnt   = hold_vld;
  assign fifo_head  = hold_data;

  // Holding-register valid flag: push only into an empty slot, pop frees it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      hold_vld <= 1'b0;
    else if (push_req && !hold_vld) hold_vld <= 1'b1;
    else if (fifo_pop)              hold_vld <= 1'b0;
  end

  // Holding-register payload
  always_ff @(posedge clk) begin
    if (push_req && !hold_vld) hold_data <= IO_mem_wdata[7:0];
  end
`endif

  // LED register and sticky overflow flag (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds     <= '0;
      overflow <= 1'b0;
    end else begin
      if (IO_mem_wr && sel_leds) leds <= IO_mem_wdata[5:0];
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
    end
  end

  // Read mux: OR of every selected register, zero when nothing is selected
  always_comb begin
    IO_mem_rdata = '0;
    if (sel_leds) IO_mem_rdata = IO_mem_rdata | {26'b0, leds};
    if (sel_stat) IO_mem_rdata = IO_mem_rdata |
                                 stat_word(fifo_full, fifo_empty, tx_busy, overflow, 8'(fifo_cnt));
  end

  // Transmitter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Transmitter next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (bit_end) state_nxt = fifo_empty ? ST_IDLE : ST_START;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Transmitter outputs: queue pop, shift-register control, next line level
  always_comb begin
    fifo_pop = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    tx_nxt   = uart_tx;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          tx_nxt   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_nxt = shreg[0];
          shift  = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            tx_nxt = 1'b1;
          end else begin
            tx_nxt = shreg[0];
            shift  = 1'b1;
          end
        end
      end
      ST_STOP: begin
        // Back-to-back frames: next start bit follows the stop bit directly
        if (bit_end && !fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          tx_nxt   = 1'b0;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  // Line register, baud counter and bit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      uart_tx <= tx_nxt;
      if (state == ST_IDLE || bit_end) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;
      if (load)                                  bit_idx <= '0;
      else if (state == ST_DATA && bit_end)      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Shift register: loaded from the queue head, LSB shifted out first
  always_ff @(posedge clk) begin
    if (load)       shreg <= fifo_head;
    else if (shift) shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: tb/tb_io_uart_leds.sv
// Testbench for io_uart_leds with DIV = 10 (1 MHz clock, 100 kbaud).
module tb_io_uart_leds;

  localparam int DIV = 10;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_leds;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic [5:0]  leds;
  logic        uart_tx;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  io_uart_leds #(
    .CLK_FREQ_HZ     (1_000_000),
    .BAUD            (100_000),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IO_mem_addr  (addr),
    .IO_mem_wdata (wdata),
    .IO_mem_wr    (wr),
    .IO_mem_rdata (rdata),
    .leds         (leds),
    .uart_tx      (uart_tx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called at a negedge; write lands on the next posedge, returns at the following negedge
  task automatic wr_io(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_io(input logic [31:0] a, output logic [31:0] d);
    addr = a; wr = 1'b0;
    #1 d = rdata;
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    addr = 32'h0040_0010; wr = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk); #1;
      if (rdata[2:1] == 2'b01) done = 1'b1;
    end
    chk("idle_reached", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_neg(input int n, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset) aborted = 1'b1;
    end
  endtask

  // Line monitor: decodes frames mid-bit and checks them against the scoreboard
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    bit         ab;
    b = '0;
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        wait_neg(4, ab);
        if (!ab) begin
          chk("mon_start_bit", {31'b0, uart_tx}, 32'd0);
          for (int i = 0; i < 8; i++) begin
            if (!ab) begin
              wait_neg(DIV, ab);
              b[i] = uart_tx;
            end
          end
          if (!ab) wait_neg(DIV, ab);
          if (!ab) begin
            chk("mon_stop_bit", {31'b0, uart_tx}, 32'd1);
            n_chk++;
            if (exp_q.size() == 0) begin
              $display("FAIL sb_unexpected_frame: got byte 0x%0h, expected no frame", b);
            end else begin
              e = exp_q.pop_front();
              if (b === e) n_pass++;
              else $display("FAIL sb_byte: got 0x%0h, expected 0x%0h", b, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t        vecs [12];
    logic [31:0] rv;
    logic [31:0] exp_stat;
    logic [9:0]  frame;
    int          nbad;
    int          busy_n;
    int          cnt;
    int          acc;
    bit          ovf;

    vecs[0]  = '{32'h0040_0010, 32'h0,         1'b0, 32'h0000_0002, 6'h00};
    vecs[1]  = '{32'h0040_0004, 32'h0,         1'b0, 32'h0000_0000, 6'h00};
    vecs[2]  = '{32'h0040_0004, 32'hFFFF_FFAA, 1'b1, 32'h0,         6'h2A};
    vecs[3]  = '{32'h0040_0004, 32'h0,         1'b0, 32'h0000_002A, 6'h2A};
    vecs[4]  = '{32'h0040_0008, 32'h0,         1'b0, 32'h0000_0000, 6'h2A};
    vecs[5]  = '{32'h0040_0000, 32'h0,         1'b0, 32'h0000_0000, 6'h2A};
    vecs[6]  = '{32'h0040_0014, 32'h0,         1'b0, 32'h0000_002A, 6'h2A};
    vecs[7]  = '{32'h0040_0000, 32'h3F,        1'b1, 32'h0,         6'h2A};
    vecs[8]  = '{32'h0040_0004, 32'h15,        1'b1, 32'h0,         6'h15};
    vecs[9]  = '{32'h0040_0014, 32'h0,         1'b0, 32'h0000_0017, 6'h15};
    vecs[10] = '{32'h0040_0010, 32'hFFFF_FFFF, 1'b1, 32'h0,         6'h15};
    vecs[11] = '{32'h0040_001C, 32'h0,         1'b0, 32'h0000_0017, 6'h15};

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_leds", {26'b0, leds}, 32'd0);

    // Register access vectors
    for (int i = 0; i < 12; i++) begin
      addr = vecs[i].addr; wdata = vecs[i].wdata; wr = vecs[i].wr;
      #1;
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_leds", i), {26'b0, leds}, {26'b0, vecs[i].exp_leds});
      @(negedge clk);
      wr = 1'b0;
    end

    // Single frame 0x55: exact latency and bit timing
    exp_q.push_back(8'h55);
    addr = 32'h0040_0008; wdata = 32'h55; wr = 1'b1;
    @(posedge clk); #1;
    chk("tx_high_at_write_edge", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);
    wr = 1'b0; addr = '0;
    @(posedge clk); #1;
    chk("tx_fall_latency", {31'b0, uart_tx}, 32'd0);
    frame = {1'b1, 8'h55, 1'b0};
    nbad = 0;
    for (int k = 0; k < 100; k++) begin
      if (uart_tx !== frame[k / 10]) nbad++;
      if (k % 10 == 5) chk($sformatf("frame55_bit%0d", k / 10), {31'b0, uart_tx}, {31'b0, frame[k / 10]});
      @(posedge clk); #1;
    end
    chk("frame55_bad_samples", nbad, 0);
    chk("tx_idle_after_frame", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);

    // Two frames with no idle gap
    exp_q.push_back(8'h41);
    wr_io(32'h0040_0008, 32'h41);
    @(negedge clk);
    exp_q.push_back(8'h42);
    wr_io(32'h0040_0008, 32'h42);
    addr = 32'h0040_0010;
    busy_n = 0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (k == 98) chk("first_stop_bit", {31'b0, uart_tx}, 32'd1);
      if (k == 99) chk("second_start_no_gap", {31'b0, uart_tx}, 32'd0);
      if (rdata[2]) busy_n++;
      else break;
      @(negedge clk);
    end
    chk("busy_cycles", busy_n, 199);
    wait_idle(500);

    // Overflow: 18 consecutive pushes while the first byte is sending
    cnt = 0; ovf = 1'b0;
    for (int i = 0; i < 18; i++) begin
      acc = (cnt < DEPTH) ? 1 : 0;
      if (acc == 1) exp_q.push_back(8'(8'h60 + i));
      else ovf = 1'b1;
      cnt = cnt + acc - ((i == 1) ? 1 : 0);
      wr_io(32'h0040_0008, 32'h60 + i);
    end
    exp_stat = {16'b0, 8'(cnt), 4'b0, ovf, 1'b1, (cnt == 0), (cnt == DEPTH)};
    rd_io(32'h0040_0010, rv);
    chk("stat_after_overflow", rv, exp_stat);
    wr_io(32'h0040_0018, 32'h08);
    rd_io(32'h0040_0010, rv);
    chk("stat_ovf_set_wins", rv, exp_stat);
    wr_io(32'h0040_0010, 32'h08);
    rd_io(32'h0040_0010, rv);
    chk("stat_ovf_cleared", rv, exp_stat & ~32'h8);
    wait_idle(3000);
    chk("sb_drained", exp_q.size(), 0);

    // Reset in the middle of a frame with another byte queued
    exp_q.push_back(8'h00);
    wr_io(32'h0040_0008, 32'h00);
    @(negedge clk);
    exp_q.push_back(8'h3C);
    wr_io(32'h0040_0008, 32'h3C);
    repeat (33) @(posedge clk);
    #1;
    chk("pre_reset_tx_low", {31'b0, uart_tx}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_tx_high", {31'b0, uart_tx}, 32'd1);
    chk("async_reset_leds", {26'b0, leds}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_io(32'h0040_0010, rv);
    chk("stat_after_reset", rv, 32'h0000_0002);
    nbad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) nbad++;
    end
    chk("no_frames_after_reset", nbad, 0);
    rd_io(32'h0040_0004, rv);
    chk("leds_read_after_reset", rv, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
